mesi_snoop_cache_ctrl: RTL and testbench
========================================

// Module: mesi_snoop_cache_ctrl
// PURPOSE
//  Per-CPU snooping coherence controller, successor to the MSI line tracker.
//  Adds E state (MESI), width-generic line count, a valid/ready CPU request port,
//  a req/gnt bus arbitration handshake, a wired-OR shared line, and upgrade-race recovery.
//  Sits between a CPU test driver and the shared snoop bus; tracks state only, no data array.
// PARAMETERS
//  NUM_LINES  4                     number of tracked lines; a line index equals its address
//  ADDR_W     $clog2(NUM_LINES)     width of every address port (minimum 1)
//  CPU        1                     CPU id, for debug/assertion messages only
// PORTS
//  clk_i            in   1       clock, single domain
//  rst_i            in   1       asynchronous, active-low reset
//  cpu_req_valid_i  in   1       CPU op request
//  cpu_req_wr_i     in   1       1=write, 0=read
//  cpu_req_addr_i   in   ADDR_W  line index
//  cpu_req_ready_o  out  1       controller accepts a request this cycle
//  cpu_done_o       out  1       1-cycle pulse when the accepted op completes
//  bus_req_o        out  1       bus request to the arbiter
//  bus_gnt_i        in   1       1-cycle grant; this cache owns the bus this cycle
//  bus_msg_o        out  2       0 Idle, 1 BusRd, 2 BusRdX, 3 BusUpgr; non-Idle only in grant cycle
//  bus_addr_o       out  ADDR_W  address for bus_msg_o; 0 when Idle
//  shared_i         in   1       wired-OR of other caches' shared_o, sampled in grant cycle
//  snp_msg_i        in   2       other caches' bus message, same encoding
//  snp_addr_i       in   ADDR_W  snooped address
//  shared_o         out  1       a snooped BusRd/BusRdX hits a non-I line here
//  flush_o          out  1       a snooped BusRd/BusRdX hits an M line here
// BEHAVIOUR
//  Line states: I=0, S=1, E=2, M=3. All lines are I at reset.
//  Reset (rst_i low, async): lines=I, FSM=IDLE, all outputs 0 incl. cpu_req_ready_o.
//    Any in-flight op is dropped with no done pulse.
//  FSM: IDLE -> (miss) WAIT_GNT -> DONE -> IDLE;  IDLE -> (hit) DONE -> IDLE.
//  cpu_req_ready_o = (state==IDLE) && !(snp_msg_i!=0 && snp_addr_i==cpu_req_addr_i).
//    A snoop hitting the requested line stalls acceptance for that cycle.
//  Accept (valid&&ready, cycle T). Op and addr are registered.
//    Read hit in S/E/M, or write to M: no bus traffic, DONE at T+1.
//    Write to E: silent E->M at the T edge, DONE at T+1.
//    Otherwise go to WAIT_GNT; bus_req_o=1 from T+1 until the grant cycle inclusive.
//  Grant cycle G: the message is chosen from the line state at G, not at accept.
//    Read, line I: BusRd; line -> E if !shared_i, else S.
//    Write, line I: BusRdX; line -> M.
//    Write, line S: BusUpgr; line -> M.
//    Upgrade race: a line invalidated by a snoop while in WAIT_GNT issues BusRdX, not BusUpgr.
//    Line update at the G edge; cpu_done_o=1 in cycle G+1 (DONE); then IDLE.
//  Snoop (snp_msg_i!=0, any FSM state), applied at the clock edge:
//    BusRd:   M->S (flush_o=1), E->S, S/I unchanged.
//    BusRdX:  M->I (flush_o=1), E/S->I.
//    BusUpgr: S->I. On an E/M line it is a protocol error: assert, state unchanged.
//  shared_o and flush_o are combinational from the current line state and snp inputs.
//  Own grant and snoop in the same cycle is illegal (the arbiter guarantees it); assert.
//  Snoop to the same line as a same-cycle local update cannot occur:
//    the accept stall and single bus ownership prevent it.
//  bus_gnt_i outside WAIT_GNT is ignored.
//  Assertions: bus_msg_o!=0 only with bus_gnt_i; flush_o implies shared_o;
//    at most one done per accepted op.
// TESTING
//  Read addr 2 from reset, gnt 3 cycles later, shared_i=0 -> bus_req_o held, BusRd@2 in gnt cycle,
//    line2=E, cpu_done_o at G+1.
//  Then write addr 2 -> no bus_req_o, line2=M, cpu_done_o at T+1.
//    Then snoop BusRd@2 -> flush_o=1, shared_o=1, line2=S.
//  Read addr 1 with shared_i=1 at grant -> line1=S.
//    Write addr 1 -> BusUpgr@1 at grant, line1=M.
//  Write addr 3 while line3=S; snoop BusRdX@3 before grant -> line3=I; at grant BusRdX@3 issued,
//    line3=M, one done pulse.
//  Snoop BusRd@0 in the same cycle as cpu_req_valid_i@0 -> ready=0 that cycle, accepted next cycle.
//  Assert rst_i low while in WAIT_GNT -> outputs 0 immediately, all lines I, no cpu_done_o.
//  NUM_LINES=8 run -> addr 7 handled the same; NUM_LINES=2 gives ADDR_W=1.

Source files
------------

// File: rtl/mesi_snoop_cache_ctrl_if.sv
// Interface bundling the CPU request port and the snoop-bus signals of one
// mesi_snoop_cache_ctrl instance.
//   master : driver side (CPU test driver, arbiter, other caches)
//   slave  : controller side
// Signals:
//   cpu_req_valid_i/wr_i/addr_i, cpu_req_ready_o  CPU valid/ready request port
//   cpu_done_o                                     op-complete pulse
//   bus_req_o, bus_gnt_i                           arbitration handshake
//   bus_msg_o, bus_addr_o                          own bus message (grant cycle only)
//   shared_i                                       wired-OR shared from other caches
//   snp_msg_i, snp_addr_i                          snooped message from other caches
//   shared_o, flush_o                              snoop responses
interface mesi_snoop_cache_ctrl_if #(
  parameter int unsigned ADDR_W = 2
);
  logic              cpu_req_valid_i;
  logic              cpu_req_wr_i;
  logic [ADDR_W-1:0] cpu_req_addr_i;
  logic              cpu_req_ready_o;
  logic              cpu_done_o;
  logic              bus_req_o;
  logic              bus_gnt_i;
  logic [1:0]        bus_msg_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic              shared_i;
  logic [1:0]        snp_msg_i;
  logic [ADDR_W-1:0] snp_addr_i;
  logic              shared_o;
  logic              flush_o;

  modport master (
    output cpu_req_valid_i, cpu_req_wr_i, cpu_req_addr_i, bus_gnt_i, shared_i,
           snp_msg_i, snp_addr_i,
    input  cpu_req_ready_o, cpu_done_o, bus_req_o, bus_msg_o, bus_addr_o, shared_o, flush_o
  );

  modport slave (
    input  cpu_req_valid_i, cpu_req_wr_i, cpu_req_addr_i, bus_gnt_i, shared_i,
           snp_msg_i, snp_addr_i,
    output cpu_req_ready_o, cpu_done_o, bus_req_o, bus_msg_o, bus_addr_o, shared_o, flush_o
  );
endinterface

// File: rtl/mesi_snoop_cache_ctrl.sv
// Per-CPU MESI snooping coherence controller. Tracks line state only (no data).
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-low reset
//   bus_io  CPU request port + snoop bus (mesi_snoop_cache_ctrl_if.slave)
// Line states: I=0, S=1, E=2, M=3. Bus messages: Idle=0, BusRd=1, BusRdX=2, BusUpgr=3.
module mesi_snoop_cache_ctrl #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned ADDR_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
  parameter int unsigned CPU       = 1
) (
  input logic                    clk_i,
  input logic                    rst_i,
  mesi_snoop_cache_ctrl_if.slave bus_io
);

  localparam logic [1:0] LineI = 2'd0;
  localparam logic [1:0] LineS = 2'd1;
  localparam logic [1:0] LineE = 2'd2;
  localparam logic [1:0] LineM = 2'd3;

  localparam logic [1:0] MsgIdle    = 2'd0;
  localparam logic [1:0] MsgBusRd   = 2'd1;
  localparam logic [1:0] MsgBusRdX  = 2'd2;
  localparam logic [1:0] MsgBusUpgr = 2'd3;

  typedef enum logic [1:0] {StIdle, StWaitGnt, StDone} state_e;

  state_e            r_state;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_bus_req;
  logic              r_done;
  logic [1:0]        r_lines   [NUM_LINES];
  logic [1:0]        w_lines_d [NUM_LINES];

  logic       w_snp_act;
  logic       w_snp_rd_any;
  logic [1:0] w_snp_line;
  logic       w_accept;
  logic [1:0] w_req_line;
  logic       w_hit;
  logic       w_gnt;
  logic [1:0] w_own_line;

  always_comb begin
    w_snp_act    = bus_io.snp_msg_i != MsgIdle;
    w_snp_rd_any = (bus_io.snp_msg_i == MsgBusRd) || (bus_io.snp_msg_i == MsgBusRdX);
    w_snp_line   = r_lines[bus_io.snp_addr_i];

    bus_io.shared_o = w_snp_rd_any && (w_snp_line != LineI);
    bus_io.flush_o  = w_snp_rd_any && (w_snp_line == LineM);

    // Gated by reset so ready is 0 while the controller is held in reset.
    bus_io.cpu_req_ready_o = rst_i && (r_state == StIdle) &&
                             !(w_snp_act && (bus_io.snp_addr_i == bus_io.cpu_req_addr_i));
    w_accept   = bus_io.cpu_req_valid_i && bus_io.cpu_req_ready_o;
    w_req_line = r_lines[bus_io.cpu_req_addr_i];
    w_hit      = bus_io.cpu_req_wr_i ? ((w_req_line == LineM) || (w_req_line == LineE))
                                     : (w_req_line != LineI);

    w_gnt      = (r_state == StWaitGnt) && bus_io.bus_gnt_i;
    w_own_line = r_lines[r_addr];

    bus_io.bus_req_o  = r_bus_req;
    bus_io.cpu_done_o = r_done;

    // Message is chosen from the line state at grant time, so a write whose S line
    // was invalidated while waiting falls back to BusRdX.
    bus_io.bus_msg_o  = MsgIdle;
    bus_io.bus_addr_o = '0;
    if (w_gnt) begin
      bus_io.bus_addr_o = r_addr;
      if (!r_wr)                   bus_io.bus_msg_o = MsgBusRd;
      else if (w_own_line == LineS) bus_io.bus_msg_o = MsgBusUpgr;
      else                         bus_io.bus_msg_o = MsgBusRdX;
    end
  end

  // Snoop, silent E->M and grant updates never target the same line in one cycle.
  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) w_lines_d[i] = r_lines[i];

    case (bus_io.snp_msg_i)
      MsgBusRd: begin
        if (w_snp_line == LineM || w_snp_line == LineE) w_lines_d[bus_io.snp_addr_i] = LineS;
      end
      MsgBusRdX:  w_lines_d[bus_io.snp_addr_i] = LineI;
      MsgBusUpgr: begin
        if (w_snp_line == LineS) w_lines_d[bus_io.snp_addr_i] = LineI;
      end
      default: ;
    endcase

    if (w_accept && bus_io.cpu_req_wr_i && (w_req_line == LineE)) begin
      w_lines_d[bus_io.cpu_req_addr_i] = LineM;
    end

    if (w_gnt) begin
      w_lines_d[r_addr] = r_wr ? LineM : (bus_io.shared_i ? LineS : LineE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_LINES; i++) r_lines[i] <= LineI;
    end else begin
      for (int i = 0; i < NUM_LINES; i++) r_lines[i] <= w_lines_d[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= StIdle;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_bus_req <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_wr   <= bus_io.cpu_req_wr_i;
            r_addr <= bus_io.cpu_req_addr_i;
            if (w_hit) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state   <= StWaitGnt;
              r_bus_req <= 1'b1;
            end
          end
        end
        StWaitGnt: begin
          if (bus_io.bus_gnt_i) begin
            r_state   <= StDone;
            r_bus_req <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifndef SYNTHESIS
  logic r_done_owed;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        r_done_owed <= 1'b0;
    else if (w_accept) r_done_owed <= 1'b1;
    else if (r_done)   r_done_owed <= 1'b0;
  end

  always @(posedge clk_i) begin
    if (rst_i) begin
      assert (bus_io.bus_msg_o == MsgIdle || bus_io.bus_gnt_i)
        else $error("cpu %0d: bus message without grant", CPU);
      assert (!bus_io.flush_o || bus_io.shared_o)
        else $error("cpu %0d: flush without shared", CPU);
      assert (!(w_gnt && w_snp_act))
        else $error("cpu %0d: own grant and snoop in the same cycle", CPU);
      assert (!(bus_io.snp_msg_i == MsgBusUpgr && (w_snp_line == LineE || w_snp_line == LineM)))
        else $error("cpu %0d: BusUpgr snooped on an E/M line", CPU);
      assert (!r_done || r_done_owed)
        else $error("cpu %0d: done pulse without an accepted op", CPU);
    end
  end
`endif

endmodule

// File: tb/tb_mesi_snoop_cache_ctrl.sv
// Self-checking bench for mesi_snoop_cache_ctrl: a transaction-level model checks the
// NUM_LINES=4 instance every cycle; directed literal checks pin key cycles; small
// NUM_LINES=8 and NUM_LINES=2 instances cover wide and 1-bit addressing.
module tb_mesi_snoop_cache_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mesi_snoop_cache_ctrl_if #(.ADDR_W(2)) bi ();
  mesi_snoop_cache_ctrl_if #(.ADDR_W(3)) b8 ();
  mesi_snoop_cache_ctrl_if #(.ADDR_W(1)) b2 ();

  mesi_snoop_cache_ctrl #(.NUM_LINES(4), .ADDR_W(2), .CPU(0)) u_dut (
    .clk_i (clk), .rst_i (rst_n), .bus_io (bi)
  );
  mesi_snoop_cache_ctrl #(.NUM_LINES(8), .ADDR_W(3), .CPU(1)) u_dut8 (
    .clk_i (clk), .rst_i (rst_n), .bus_io (b8)
  );
  mesi_snoop_cache_ctrl #(.NUM_LINES(2), .ADDR_W(1), .CPU(2)) u_dut2 (
    .clk_i (clk), .rst_i (rst_n), .bus_io (b2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model of the 4-line instance ----------------
  // Lines: 0=I 1=S 2=E 3=M. An op is either waiting for the bus or owes a done pulse.
  int m_line [4];
  bit m_wait_bus, m_wr, m_done_due;
  int m_addr;
  int n_line [4];
  bit n_wait_bus, n_wr, n_done_due;
  int n_addr;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_line[i] = 0;
    m_wait_bus = 0; m_wr = 0; m_done_due = 0; m_addr = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        chk("m_rst_ready", bi.cpu_req_ready_o, 0);
        chk("m_rst_done", bi.cpu_done_o, 0);
        chk("m_rst_breq", bi.bus_req_o, 0);
        chk("m_rst_msg", bi.bus_msg_o, 0);
        chk("m_rst_shared", bi.shared_o, 0);
        chk("m_rst_flush", bi.flush_o, 0);
        n_line = m_line; n_wait_bus = 0; n_wr = 0; n_done_due = 0; n_addr = 0;
      end else begin
        int  sa, ra, sl, rl, msg, e_msg, e_addr;
        bit  e_ready, grant, reads, hit;
        sa = int'(bi.snp_addr_i); ra = int'(bi.cpu_req_addr_i); msg = int'(bi.snp_msg_i);
        sl = m_line[sa]; rl = m_line[ra];
        e_ready = !(m_wait_bus || m_done_due) && !(msg != 0 && sa == ra);
        grant = m_wait_bus && bi.bus_gnt_i;
        e_msg = 0; e_addr = 0;
        if (grant) begin
          e_addr = m_addr;
          e_msg  = !m_wr ? 1 : (m_line[m_addr] == 1 ? 3 : 2);
        end
        reads = (msg == 1 || msg == 2);
        chk("m_ready", bi.cpu_req_ready_o, e_ready);
        chk("m_done", bi.cpu_done_o, m_done_due);
        chk("m_breq", bi.bus_req_o, m_wait_bus);
        chk("m_msg", bi.bus_msg_o, e_msg);
        chk("m_baddr", bi.bus_addr_o, e_addr);
        chk("m_shared", bi.shared_o, reads && sl != 0);
        chk("m_flush", bi.flush_o, reads && sl == 3);
        n_line = m_line; n_wait_bus = m_wait_bus; n_wr = m_wr; n_addr = m_addr;
        n_done_due = 0;
        if (grant) begin
          n_wait_bus = 0; n_done_due = 1;
          n_line[m_addr] = m_wr ? 3 : (bi.shared_i ? 1 : 2);
        end
        if (msg == 1 && sl >= 2) n_line[sa] = 1;
        if (msg == 2) n_line[sa] = 0;
        if (msg == 3 && sl == 1) n_line[sa] = 0;
        if (bi.cpu_req_valid_i && e_ready) begin
          hit = bi.cpu_req_wr_i ? (rl >= 2) : (rl != 0);
          if (hit) begin
            n_done_due = 1;
            if (bi.cpu_req_wr_i && rl == 2) n_line[ra] = 3;
          end else begin
            n_wait_bus = 1; n_wr = bi.cpu_req_wr_i; n_addr = ra;
          end
        end
      end
      @(posedge clk);
      if (rst_n) begin
        m_line = n_line; m_wait_bus = n_wait_bus; m_wr = n_wr;
        m_addr = n_addr; m_done_due = n_done_due;
      end else begin
        model_reset();
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input bit v, input bit wr, input int a);
    bi.cpu_req_valid_i = v; bi.cpu_req_wr_i = wr; bi.cpu_req_addr_i = 2'(a);
  endtask

  task automatic snp(input int m, input int a);
    bi.snp_msg_i = 2'(m); bi.snp_addr_i = 2'(a);
  endtask

  // Miss op: accept, wait `gap` cycles from accept to grant, check message and done.
  task automatic miss_op(input string nm, input bit wr, input int a, input int gap,
                         input bit sh, input int exp_msg);
    req(1, wr, a);
    tick();
    req(0, 0, 0);
    for (int i = 1; i < gap; i++) begin
      #1 chk({nm, "_breq_wait"}, bi.bus_req_o, 1);
      tick();
    end
    bi.bus_gnt_i = 1; bi.shared_i = sh;
    #1 chk({nm, "_msg"}, bi.bus_msg_o, exp_msg);
    chk({nm, "_addr"}, bi.bus_addr_o, a);
    tick();
    bi.bus_gnt_i = 0; bi.shared_i = 0;
    #1 chk({nm, "_done"}, bi.cpu_done_o, 1);
    chk({nm, "_breq_off"}, bi.bus_req_o, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    rst_n = 0;
    req(0, 0, 0); snp(0, 0); bi.bus_gnt_i = 0; bi.shared_i = 0;
    b8.cpu_req_valid_i = 0; b8.cpu_req_wr_i = 0; b8.cpu_req_addr_i = 0;
    b8.bus_gnt_i = 0; b8.shared_i = 0; b8.snp_msg_i = 0; b8.snp_addr_i = 0;
    b2.cpu_req_valid_i = 0; b2.cpu_req_wr_i = 0; b2.cpu_req_addr_i = 0;
    b2.bus_gnt_i = 0; b2.shared_i = 0; b2.snp_msg_i = 0; b2.snp_addr_i = 0;
    #1 chk("reset_ready", bi.cpu_req_ready_o, 0);
    chk("reset_breq", bi.bus_req_o, 0);
    repeat (2) tick();
    rst_n = 1;
    tick();

    // Read 2 from reset, grant 3 cycles after accept, not shared -> E.
    req(1, 0, 2);
    #1 chk("rd2_ready", bi.cpu_req_ready_o, 1);
    tick();
    miss_op_tail_rd2();

    // Write 2 hits E: silent, done next cycle.
    req(1, 1, 2);
    tick();
    req(0, 0, 0);
    #1 chk("wr2_breq", bi.bus_req_o, 0);
    chk("wr2_done", bi.cpu_done_o, 1);
    tick();

    // Snoop BusRd@2 on M -> flush+shared, then S -> shared only.
    snp(1, 2);
    #1 chk("snp2_flush", bi.flush_o, 1);
    chk("snp2_shared", bi.shared_o, 1);
    tick();
    #1 chk("snp2b_flush", bi.flush_o, 0);
    chk("snp2b_shared", bi.shared_o, 1);
    tick();
    snp(0, 0);

    // Read 1 shared -> S; write 1 -> BusUpgr.
    miss_op("rd1", 0, 1, 2, 1, 1);
    miss_op("wr1", 1, 1, 1, 0, 3);

    // Line 3 to S, then write 3 with an invalidating snoop before grant.
    miss_op("rd3", 0, 3, 1, 1, 1);
    req(1, 1, 3);
    tick();
    req(0, 0, 0);
    snp(2, 3);
    #1 chk("race_shared", bi.shared_o, 1);
    chk("race_breq", bi.bus_req_o, 1);
    tick();
    snp(0, 0);
    bi.bus_gnt_i = 1;
    #1 chk("race_msg", bi.bus_msg_o, 2);
    chk("race_addr", bi.bus_addr_o, 3);
    tick();
    bi.bus_gnt_i = 0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      #1 dones += int'(bi.cpu_done_o);
      tick();
    end
    chk("race_one_done", dones, 1);
    snp(1, 3);
    #1 chk("race_line_m", bi.flush_o, 1);
    tick();
    snp(0, 0);

    // Snoop to the requested line stalls acceptance for one cycle.
    req(1, 0, 0);
    snp(1, 0);
    #1 chk("stall_ready", bi.cpu_req_ready_o, 0);
    tick();
    snp(0, 0);
    #1 chk("stall_ready_next", bi.cpu_req_ready_o, 1);
    tick();
    req(0, 0, 0);
    #1 chk("stall_breq", bi.bus_req_o, 1);
    bi.bus_gnt_i = 1;
    #1 chk("stall_msg", bi.bus_msg_o, 1);
    tick();
    bi.bus_gnt_i = 0;
    #1 chk("stall_done", bi.cpu_done_o, 1);
    tick();

    // Reset while waiting for grant (line 2 is S, so the write needs an upgrade).
    req(1, 1, 2);
    tick();
    req(0, 0, 0);
    #1 chk("rstw_breq", bi.bus_req_o, 1);
    tick();
    rst_n = 0;
    #1 chk("rstw_breq0", bi.bus_req_o, 0);
    chk("rstw_ready0", bi.cpu_req_ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1 chk("rstw_nodone", bi.cpu_done_o, 0);
    end
    rst_n = 1;
    tick();
    snp(1, 1);
    #1 chk("rstw_line1_i", bi.shared_o, 0);
    tick();
    snp(1, 3);
    #1 chk("rstw_line3_i", bi.shared_o, 0);
    tick();
    snp(0, 0);
    miss_op("rstw_rd0", 0, 0, 1, 0, 1);

    // NUM_LINES=8: top address 7.
    b8.cpu_req_valid_i = 1; b8.cpu_req_addr_i = 3'd7;
    tick();
    b8.cpu_req_valid_i = 0;
    #1 chk("n8_breq", b8.bus_req_o, 1);
    b8.bus_gnt_i = 1;
    #1 chk("n8_msg", b8.bus_msg_o, 1);
    chk("n8_addr", b8.bus_addr_o, 7);
    tick();
    b8.bus_gnt_i = 0;
    #1 chk("n8_done", b8.cpu_done_o, 1);
    tick();
    b8.cpu_req_valid_i = 1; b8.cpu_req_wr_i = 1;
    tick();
    b8.cpu_req_valid_i = 0; b8.cpu_req_wr_i = 0;
    #1 chk("n8_wr_silent", b8.bus_req_o, 0);
    chk("n8_wr_done", b8.cpu_done_o, 1);
    tick();

    // NUM_LINES=2: 1-bit address, shared read then upgrade.
    b2.cpu_req_valid_i = 1; b2.cpu_req_addr_i = 1'b1;
    tick();
    b2.cpu_req_valid_i = 0;
    b2.bus_gnt_i = 1; b2.shared_i = 1;
    #1 chk("n2_msg", b2.bus_msg_o, 1);
    chk("n2_addr", b2.bus_addr_o, 1);
    tick();
    b2.bus_gnt_i = 0; b2.shared_i = 0;
    tick();
    b2.cpu_req_valid_i = 1; b2.cpu_req_wr_i = 1;
    tick();
    b2.cpu_req_valid_i = 0; b2.cpu_req_wr_i = 0;
    b2.bus_gnt_i = 1;
    #1 chk("n2_upgr", b2.bus_msg_o, 3);
    tick();
    b2.bus_gnt_i = 0;
    #1 chk("n2_done", b2.cpu_done_o, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Remainder of the first read: bus_req held for T+1..T+3, grant at T+3.
  task automatic miss_op_tail_rd2();
    req(0, 0, 0);
    #1 chk("rd2_breq_t1", bi.bus_req_o, 1);
    chk("rd2_nodone", bi.cpu_done_o, 0);
    tick();
    #1 chk("rd2_breq_t2", bi.bus_req_o, 1);
    tick();
    bi.bus_gnt_i = 1; bi.shared_i = 0;
    #1 chk("rd2_msg", bi.bus_msg_o, 1);
    chk("rd2_addr", bi.bus_addr_o, 2);
    chk("rd2_breq_g", bi.bus_req_o, 1);
    tick();
    bi.bus_gnt_i = 0;
    #1 chk("rd2_done", bi.cpu_done_o, 1);
    chk("rd2_msg_idle", bi.bus_msg_o, 0);
    tick();
    #1 chk("rd2_done_once", bi.cpu_done_o, 0);
  endtask

endmodule
